// File: rtl/d_cache_v2_if.sv
// Core-side and memory-side bus bundle for d_cache_v2.
// slave  : the cache's view (takes core requests, issues memory requests).
// master : the environment's view (issues core requests, answers memory requests).
// Signals: core_req/we/wstrb/addr/wdata -> core_ready/rvalid/rdata/err,
//          mem_req/we/wstrb/addr/wdata   -> mem_ack/rdata.
interface d_cache_v2_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [3:0]        core_wstrb;
  logic [ADDR_W-1:0] core_addr;
  logic [31:0]       core_wdata;
  logic              core_ready;
  logic              core_rvalid;
  logic [31:0]       core_rdata;
  logic              core_err;

  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output core_req, core_we, core_wstrb, core_addr, core_wdata,
    input  core_ready, core_rvalid, core_rdata, core_err,
    input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

  modport slave (
    input  core_req, core_we, core_wstrb, core_addr, core_wdata,
    output core_ready, core_rvalid, core_rdata, core_err,
    output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );
endinterface

// File: rtl/d_cache_v2.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Ports: clk, rst_n (async, active-low), bus (d_cache_v2_if.slave: core request /
// completion and memory request / ack), flush (invalidate all lines),
// hit_cnt / miss_cnt (saturating load hit / miss counters).
// Core completion outputs and core_ready are decoded from state in the same cycle
// so that a load hit completes one cycle after accept and a refill completes with mem_ack.
module d_cache_v2 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SETS   = 256,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  d_cache_v2_if.slave      bus,
  input  logic             flush,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned TAG_W  = ADDR_W - 2 - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESP, FLUSH} state_t;
  state_t state, state_nx;

  logic [WORD_W-1:0] word_q;
  logic              we_q;
  logic [3:0]        strb_q;
  logic [31:0]       data_q;
  logic [SETS-1:0]   valid_q;
  logic              flush_pend;

  logic [31:0]       data_ram [SETS];
  logic [TAG_W-1:0]  tag_ram  [SETS];
  logic [31:0]       rd_word;
  logic [TAG_W-1:0]  rd_tag;

  logic [IDX_W-1:0]  idx_in, idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic              ready_c, accept, take_flush, hit;
  logic              rvalid, err, mreq, mwe, tag_we, hit_inc, miss_inc;
  logic [31:0]       rdata, mwdata, ram_wdata;
  logic [3:0]        mstrb, ram_be;
  logic [ADDR_W-1:0] maddr;
  logic              unused_addr_bits;

  // Only these strobe patterns describe a naturally aligned byte, half or word.
  function automatic logic strb_legal(input logic [3:0] s);
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Replicate low-lane packed data onto the strobed lanes; other lanes are zero.
  function automatic logic [31:0] steer(input logic [3:0] s, input logic [31:0] d);
    logic [31:0] rep;
    rep = '0;
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: rep = {4{d[7:0]}};
      4'b0011, 4'b1100:                   rep = {2{d[15:0]}};
      4'b1111:                            rep = d;
      default:                            rep = '0;
    endcase
    return rep & {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  assign unused_addr_bits = ^bus.core_addr[1:0];
  assign idx_in     = bus.core_addr[2 +: IDX_W];
  assign idx_q      = word_q[IDX_W-1:0];
  assign tag_q      = word_q[WORD_W-1:IDX_W];
  assign take_flush = (state == IDLE) && (flush || flush_pend);
  assign ready_c    = rst_n && (state == IDLE) && !flush && !flush_pend;
  assign accept     = bus.core_req && ready_c;
  assign hit        = valid_q[idx_q] && (rd_tag == tag_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and per-state outputs.
  always_comb begin
    state_nx  = state;
    rvalid    = 1'b0;
    rdata     = '0;
    err       = 1'b0;
    mreq      = 1'b0;
    mwe       = 1'b0;
    mstrb     = '0;
    mwdata    = '0;
    maddr     = '0;
    ram_be    = '0;
    ram_wdata = data_q;
    tag_we    = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (take_flush) state_nx = FLUSH;
        else if (accept)
          state_nx = (bus.core_we && !strb_legal(bus.core_wstrb)) ? RESP : LOOKUP;
      end
      LOOKUP: begin
        if (we_q) begin
          if (hit) ram_be = strb_q;
          state_nx = WRITE;
        end else if (hit) begin
          rvalid   = 1'b1;
          rdata    = rd_word;
          hit_inc  = 1'b1;
          state_nx = IDLE;
        end else begin
          miss_inc = 1'b1;
          state_nx = REFILL;
        end
      end
      REFILL: begin
        mreq  = 1'b1;
        maddr = {word_q, 2'b00};
        if (bus.mem_ack) begin
          ram_be    = 4'hF;
          ram_wdata = bus.mem_rdata;
          tag_we    = 1'b1;
          rvalid    = 1'b1;
          rdata     = bus.mem_rdata;
          state_nx  = IDLE;
        end
      end
      WRITE: begin
        mreq   = 1'b1;
        mwe    = 1'b1;
        mstrb  = strb_q;
        mwdata = data_q;
        maddr  = {word_q, 2'b00};
        if (bus.mem_ack) begin
          rvalid   = 1'b1;
          state_nx = IDLE;
        end
      end
      RESP: begin
        rvalid   = 1'b1;
        err      = 1'b1;
        state_nx = IDLE;
      end
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Accepted request; store data is lane-steered once here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      we_q   <= 1'b0;
      strb_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      word_q <= bus.core_addr[ADDR_W-1:2];
      we_q   <= bus.core_we;
      strb_q <= bus.core_wstrb;
      data_q <= steer(bus.core_wstrb, bus.core_wdata);
    end
  end

  // Data/tag RAMs: read on accept, byte-enabled write from LOOKUP or REFILL.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_word <= data_ram[idx_in];
      rd_tag  <= tag_ram[idx_in];
    end
    for (int b = 0; b < 4; b++) begin
      if (ram_be[b]) data_ram[idx_q][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    if (tag_we) tag_ram[idx_q] <= tag_q;
  end

  // Valid bits, pending flush and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      flush_pend <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      if (state == FLUSH) valid_q <= '0;
      else if (tag_we)    valid_q[idx_q] <= 1'b1;
      flush_pend <= take_flush ? 1'b0 : (flush_pend || flush);
      if (hit_inc && (hit_cnt != '1))   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (miss_inc && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  assign bus.core_ready  = ready_c;
  assign bus.core_rvalid = rvalid;
  assign bus.core_rdata  = rdata;
  assign bus.core_err    = err;
  assign bus.mem_req     = mreq;
  assign bus.mem_we      = mwe;
  assign bus.mem_wstrb   = mstrb;
  assign bus.mem_addr    = maddr;
  assign bus.mem_wdata   = mwdata;
endmodule

// File: tb/tb_d_cache_v2.sv
// Self-checking bench for d_cache_v2: vector table plus flush and reset sequences,
// with a memory responder model and a completion scoreboard.
module tb_d_cache_v2;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] hit_cnt, miss_cnt;

  d_cache_v2_if #(.ADDR_W(32)) bus ();

  d_cache_v2 #(.ADDR_W(32), .SETS(256), .CNT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .flush    (flush),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  typedef struct {
    logic        we;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_mem;   // -1 none, 0 read, 1 write
    logic [3:0]  exp_mstrb;
    logic [31:0] exp_mdata;
    int          exp_lat;   // 0 = not checked
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          tests, errs;
  int          cyc, acc_cyc, last_rv_cyc, done_cnt;
  int          txn_cnt, wait_cnt;
  logic        last_we;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_strb;
  bit          hold_ack;
  string       cur_name;
  logic [31:0] mem_model [0:1023];
  vec_t        vt [20];

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] strb, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] er, input logic ee,
                              input int em, input logic [3:0] ms, input logic [31:0] md,
                              input int lat);
    vec_t v;
    v.we = we; v.strb = strb; v.addr = addr; v.wdata = wdata; v.exp_rdata = er;
    v.exp_err = ee; v.exp_mem = em; v.exp_mstrb = ms; v.exp_mdata = md; v.exp_lat = lat;
    return v;
  endfunction

  // Memory responder: acks on the second cycle a request is seen.
  initial begin
    wait_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_ack) begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        wait_cnt      = 0;
      end else if (bus.mem_req) begin
        if (wait_cnt == 0) begin
          txn_cnt++;
          last_we    = bus.mem_we;
          last_addr  = bus.mem_addr;
          last_strb  = bus.mem_wstrb;
          last_wdata = bus.mem_wdata;
        end
        wait_cnt++;
        if (wait_cnt >= 2 && !hold_ack) begin
          if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
              if (bus.mem_wstrb[b]) mem_model[bus.mem_addr[11:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
          end else begin
            bus.mem_rdata = mem_model[bus.mem_addr[11:2]];
          end
          bus.mem_ack = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Completion monitor: pops the scoreboard on every core_rvalid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.core_rvalid) begin
        last_rv_cyc = cyc;
        done_cnt++;
        if (sb.size() == 0) begin
          tests++;
          errs++;
          $display("FAIL %s_unexpected_rvalid: got rdata %h err %0b, required no response",
                   cur_name, bus.core_rdata, bus.core_err);
        end else begin
          e = sb.pop_front();
          chk({cur_name, "_rdata"}, bus.core_rdata, e.rdata);
          chk({cur_name, "_err"}, 32'(bus.core_err), 32'(e.err));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input bit with_flush, input bit expect_resp);
    int  t0, d0;
    bit  acc;
    exp_t e;
    t0  = txn_cnt;
    d0  = done_cnt;
    acc = 1'b0;
    @(posedge clk); #1;
    bus.core_req   = 1'b1;
    bus.core_we    = v.we;
    bus.core_wstrb = v.strb;
    bus.core_addr  = v.addr;
    bus.core_wdata = v.wdata;
    flush          = with_flush;
    if (expect_resp) begin
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      sb.push_back(e);
    end
    if (with_flush) begin
      @(negedge clk);
      chk({cur_name, "_ready_during_flush"}, 32'(bus.core_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
    end
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (bus.core_ready) begin
        acc     = 1'b1;
        acc_cyc = cyc;
      end
    end
    if (!acc) chk({cur_name, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_wstrb = '0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    if (!expect_resp) return;
    for (int i = 0; i < 40 && done_cnt == d0; i++) @(posedge clk);
    chk({cur_name, "_done"}, 32'(done_cnt != d0), 32'd1);
    if (v.exp_lat != 0) chk({cur_name, "_latency"}, 32'(last_rv_cyc - acc_cyc), 32'(v.exp_lat));
    if (v.exp_mem < 0) begin
      chk({cur_name, "_no_mem_req"}, 32'(txn_cnt - t0), 32'd0);
    end else begin
      chk({cur_name, "_mem_txns"}, 32'(txn_cnt - t0), 32'd1);
      chk({cur_name, "_mem_we"}, 32'(last_we), 32'(v.exp_mem));
      chk({cur_name, "_mem_addr"}, last_addr, {v.addr[31:2], 2'b00});
      if (v.exp_mem == 1) begin
        chk({cur_name, "_mem_wstrb"}, 32'(last_strb), 32'(v.exp_mstrb));
        chk({cur_name, "_mem_wdata"}, last_wdata, v.exp_mdata);
      end
    end
  endtask

  initial begin
    bit seen;
    tests = 0; errs = 0; done_cnt = 0; txn_cnt = 0; last_rv_cyc = 0; acc_cyc = 0;
    hold_ack = 1'b0; cur_name = "reset";
    last_we = 1'b0; last_addr = '0; last_wdata = '0; last_strb = '0;
    rst_n = 1'b0; flush = 1'b0;
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_wstrb = '0;
    bus.core_addr = '0; bus.core_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem_model[i] = '0;
    mem_model[32'h40 >> 2]  = 32'hDEADBEEF;
    mem_model[32'h400 >> 2] = 32'h11223344;

    //        we strb   addr        wdata        exp_rdata    err mem ms     mdata        lat
    vt[0]  = mk(0, 4'h0, 32'h40,  32'h0,        32'hDEADBEEF, 0,  0, 4'h0, 32'h0,        0);
    vt[1]  = mk(0, 4'h0, 32'h40,  32'h0,        32'hDEADBEEF, 0, -1, 4'h0, 32'h0,        1);
    vt[2]  = mk(1, 4'h4, 32'h40,  32'h000000AA, 32'h0,        0,  1, 4'h4, 32'h00AA0000, 0);
    vt[3]  = mk(0, 4'h0, 32'h40,  32'h0,        32'hDEAABEEF, 0, -1, 4'h0, 32'h0,        1);
    vt[4]  = mk(1, 4'h6, 32'h40,  32'hFFFFFFFF, 32'h0,        1, -1, 4'h0, 32'h0,        1);
    vt[5]  = mk(0, 4'h0, 32'h40,  32'h0,        32'hDEAABEEF, 0, -1, 4'h0, 32'h0,        1);
    vt[6]  = mk(1, 4'hF, 32'h400, 32'hCAFEF00D, 32'h0,        0,  1, 4'hF, 32'hCAFEF00D, 0);
    vt[7]  = mk(0, 4'h0, 32'h40,  32'h0,        32'hDEAABEEF, 0, -1, 4'h0, 32'h0,        1);
    vt[8]  = mk(0, 4'h0, 32'h400, 32'h0,        32'hCAFEF00D, 0,  0, 4'h0, 32'h0,        0);
    vt[9]  = mk(0, 4'h0, 32'h400, 32'h0,        32'hCAFEF00D, 0, -1, 4'h0, 32'h0,        1);
    vt[10] = mk(1, 4'hC, 32'h402, 32'hAAAABEEF, 32'h0,        0,  1, 4'hC, 32'hBEEF0000, 0);
    vt[11] = mk(0, 4'h0, 32'h400, 32'h0,        32'hBEEFF00D, 0, -1, 4'h0, 32'h0,        1);
    vt[12] = mk(1, 4'h3, 32'h400, 32'h00001234, 32'h0,        0,  1, 4'h3, 32'h00001234, 0);
    vt[13] = mk(1, 4'h1, 32'h44,  32'h00000077, 32'h0,        0,  1, 4'h1, 32'h00000077, 0);
    vt[14] = mk(0, 4'h0, 32'h44,  32'h0,        32'h00000077, 0,  0, 4'h0, 32'h0,        0);
    vt[15] = mk(1, 4'h8, 32'h44,  32'hFFFFFF55, 32'h0,        0,  1, 4'h8, 32'h55000000, 0);
    vt[16] = mk(0, 4'h0, 32'h400, 32'h0,        32'hBEEF1234, 0, -1, 4'h0, 32'h0,        1);
    vt[17] = mk(0, 4'h0, 32'h44,  32'h0,        32'h55000077, 0, -1, 4'h0, 32'h0,        1);
    vt[18] = mk(0, 4'h5, 32'h40,  32'h0,        32'hDEAABEEF, 0, -1, 4'h0, 32'h0,        1);
    vt[19] = mk(1, 4'hA, 32'h400, 32'h0,        32'h0,        1, -1, 4'h0, 32'h0,        1);

    // Reset values while reset is held.
    #12;
    chk("reset_ready", 32'(bus.core_ready), 32'd0);
    chk("reset_rvalid_err", {30'd0, bus.core_rvalid, bus.core_err}, 32'd0);
    chk("reset_rdata", bus.core_rdata, 32'd0);
    chk("reset_mem_req_we", {30'd0, bus.mem_req, bus.mem_we}, 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    chk("reset_mem_wdata_wstrb", bus.mem_wdata | 32'(bus.mem_wstrb), 32'd0);
    chk("reset_hit_cnt", hit_cnt, 32'd0);
    chk("reset_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cur_name = $sformatf("v%0d", i);
      run_vec(vt[i], 1'b0, 1'b1);
    end
    chk("table_hit_cnt", hit_cnt, 32'd9);
    chk("table_miss_cnt", miss_cnt, 32'd3);

    // Flush together with a request: flush wins, then the line refills.
    cur_name = "flush_load";
    run_vec(mk(0, 4'h0, 32'h40, 32'h0, 32'hDEAABEEF, 0, 0, 4'h0, 32'h0, 0), 1'b1, 1'b1);
    chk("flush_hit_cnt", hit_cnt, 32'd9);
    chk("flush_miss_cnt", miss_cnt, 32'd4);

    // Reset asserted while a refill is outstanding.
    cur_name = "reset_refill";
    hold_ack = 1'b1;
    run_vec(mk(0, 4'h0, 32'h44, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 0), 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_req;
    end
    chk("reset_refill_mem_req_seen", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_refill_mem_req_drop", 32'(bus.mem_req), 32'd0);
    chk("reset_refill_rvalid", 32'(bus.core_rvalid), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    hold_ack = 1'b0;
    repeat (10) @(posedge clk);
    chk("post_reset_hit_cnt", hit_cnt, 32'd0);
    chk("post_reset_miss_cnt", miss_cnt, 32'd0);

    cur_name = "post_reset_load";
    run_vec(mk(0, 4'h0, 32'h40, 32'h0, 32'hDEAABEEF, 0, 0, 4'h0, 32'h0, 0), 1'b0, 1'b1);
    chk("post_reset_load_miss_cnt", miss_cnt, 32'd1);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
